mc_ctrl: RTL and testbench

Multi-cycle successor to the single-cycle MIPS control decoder. A state machine sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over a shared memory port with a req/ack handshake, and adds lw/sw, bne, jal link write-back and jr. It sits between the datapath (PC, IR, register file, ALU, NPC) and the unified instruction/data memory, and drives the same control-field encodings the datapath already accepts.

---
 rtl/mc_ctrl_pkg.sv | 77 +++++++
 rtl/mc_ctrl_dec.sv | 62 ++++++
 rtl/mc_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_mc_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, instruction
// classes, datapath select codes, opcodes and funct values.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_BR, CL_LD, CL_ST, CL_J, CL_JAL, CL_JR, CL_ILL
  } cls_e;

  localparam logic [2:0] NPC_PLUS4  = 3'd0;
  localparam logic [2:0] NPC_BRANCH = 3'd1;
  localparam logic [2:0] NPC_JUMP   = 3'd2;
  localparam logic [2:0] NPC_JR     = 3'd3;
  localparam logic [2:0] NPC_EXCEPT = 3'd4;

  localparam logic [1:0] EXT_ZERO   = 2'd0;
  localparam logic [1:0] EXT_SIGNED = 2'd1;
  localparam logic [1:0] EXT_LUI    = 2'd2;

  localparam logic [1:0] GPRSel_RD = 2'd0;
  localparam logic [1:0] GPRSel_RT = 2'd1;
  localparam logic [1:0] GPRSel_RA = 2'd2;

  localparam logic [2:0] WDSel_FromALU = 3'd0;
  localparam logic [2:0] WDSel_FromMEM = 3'd1;
  localparam logic [2:0] WDSel_FromPC  = 3'd2;

  localparam logic [4:0] ALU_NOP  = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_ADDU = 5'd2;
  localparam logic [4:0] ALU_SUB  = 5'd3;
  localparam logic [4:0] ALU_SUBU = 5'd4;
  localparam logic [4:0] ALU_AND  = 5'd5;
  localparam logic [4:0] ALU_OR   = 5'd6;
  localparam logic [4:0] ALU_XOR  = 5'd7;
  localparam logic [4:0] ALU_NOR  = 5'd8;
  localparam logic [4:0] ALU_SLT  = 5'd9;
  localparam logic [4:0] ALU_SLL  = 5'd10;
  localparam logic [4:0] ALU_SRL  = 5'd11;
  localparam logic [4:0] ALU_LUI  = 5'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational opcode/funct classifier: instruction class plus the ALU-side
// controls (ALUOp, shift-amount A select, immediate B select, extender mode).
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W = 5
) (
  input  logic [5:0]         op_i,
  input  logic [5:0]         fn_i,
  output cls_e               cls_o,
  output logic [ALUOP_W-1:0] aluop_o,
  output logic               asel_o,
  output logic               bsel_o,
  output logic [1:0]         extop_o
);

  logic [4:0] alu;

  always_comb begin
    cls_o   = CL_ILL;
    alu     = ALU_NOP;
    asel_o  = 1'b0;
    bsel_o  = 1'b0;
    extop_o = EXT_ZERO;
    case (op_i)
      OP_RTYPE: begin
        cls_o = CL_R;
        case (fn_i)
          FN_ADD:  alu = ALU_ADD;
          FN_ADDU: alu = ALU_ADDU;
          FN_SUB:  alu = ALU_SUB;
          FN_SUBU: alu = ALU_SUBU;
          FN_AND:  alu = ALU_AND;
          FN_OR:   alu = ALU_OR;
          FN_XOR:  alu = ALU_XOR;
          FN_NOR:  alu = ALU_NOR;
          FN_SLT:  alu = ALU_SLT;
          FN_SLL:  begin alu = ALU_SLL; asel_o = 1'b1; end
          FN_SRL:  begin alu = ALU_SRL; asel_o = 1'b1; end
          FN_JR:   cls_o = CL_JR;
          default: cls_o = CL_ILL;
        endcase
      end
      OP_ADDI:  begin cls_o = CL_I; alu = ALU_ADD;  bsel_o = 1'b1; extop_o = EXT_SIGNED; end
      OP_ADDIU: begin cls_o = CL_I; alu = ALU_ADDU; bsel_o = 1'b1; extop_o = EXT_SIGNED; end
      OP_SLTI:  begin cls_o = CL_I; alu = ALU_SLT;  bsel_o = 1'b1; extop_o = EXT_SIGNED; end
      OP_ANDI:  begin cls_o = CL_I; alu = ALU_AND;  bsel_o = 1'b1; end
      OP_ORI:   begin cls_o = CL_I; alu = ALU_OR;   bsel_o = 1'b1; end
      OP_LUI:   begin cls_o = CL_I; alu = ALU_LUI;  bsel_o = 1'b1; extop_o = EXT_LUI; end
      // Branch compare runs through SUBU so Zero reflects rs == rt
      OP_BEQ, OP_BNE: begin cls_o = CL_BR; alu = ALU_SUBU; extop_o = EXT_SIGNED; end
      OP_LW:    begin cls_o = CL_LD; alu = ALU_ADD; bsel_o = 1'b1; extop_o = EXT_SIGNED; end
      OP_SW:    begin cls_o = CL_ST; alu = ALU_ADD; bsel_o = 1'b1; extop_o = EXT_SIGNED; end
      OP_J:     cls_o = CL_J;
      OP_JAL:   cls_o = CL_JAL;
      default:  cls_o = CL_ILL;
    endcase
  end

  assign aluop_o = ALUOP_W'(alu);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) over a shared memory
// port. Define MC_CTRL_TRAP_EN for the TRAP state, illegal-op trap and bus timeout.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 5,
  parameter int TMO_W       = 4,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  input  logic               Zero,
  input  logic               stall,
  input  logic               mem_ack,
  output logic               mem_req,
  output logic               mem_we,
  output logic               IRWr,
  output logic               PCWr,
  output logic               RFWr,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [2:0]         NPCOp,
  output logic [1:0]         EXTOp,
  output logic [1:0]         GPRSel,
  output logic [2:0]         WDSel,
  output logic               ASel,
  output logic               BSel,
  output logic               retire,
  output logic [2:0]         state
);

  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT >= (1 << TMO_W)) begin : g_tmo_chk
    $error("MEM_TIMEOUT does not fit in TMO_W bits");
  end

  state_e             state_q;
  logic [5:0]         op_q, fn_q;
  logic               run_q;
  cls_e               cls;
  logic [ALUOP_W-1:0] dec_alu;
  logic               dec_asel, dec_bsel;
  logic [1:0]         dec_ext;
  logic               ack_v, alu_en;
  logic               ir_wr, pc_wr, rf_wr, ret;

  mc_ctrl_dec #(.ALUOP_W(ALUOP_W)) u_dec (
    .op_i    (op_q),
    .fn_i    (fn_q),
    .cls_o   (cls),
    .aluop_o (dec_alu),
    .asel_o  (dec_asel),
    .bsel_o  (dec_bsel),
    .extop_o (dec_ext)
  );

  // run_q keeps mem_req low through reset and drops it asynchronously on reassert
  assign mem_req = run_q & ((state_q == ST_FETCH) | (state_q == ST_MEM));
  assign ack_v   = mem_req & mem_ack;

`ifdef MC_CTRL_TRAP_EN
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_FETCH;
      op_q    <= '0;
      fn_q    <= '0;
      run_q   <= 1'b0;
`ifdef MC_CTRL_TRAP_EN
      tmo_q   <= '0;
`endif
    end else begin
      run_q <= 1'b1;
      if (!stall) begin
        case (state_q)
          ST_FETCH: if (ack_v) begin
            state_q <= ST_DECODE;
            op_q    <= opcode;
            fn_q    <= funct;
          end
          ST_DECODE: case (cls)
            CL_J, CL_JAL: state_q <= ST_FETCH;
`ifdef MC_CTRL_TRAP_EN
            CL_ILL:       state_q <= ST_TRAP;
`else
            CL_ILL:       state_q <= ST_FETCH;
`endif
            default:      state_q <= ST_EXEC;
          endcase
          ST_EXEC: case (cls)
            CL_LD, CL_ST: state_q <= ST_MEM;
            CL_R, CL_I:   state_q <= ST_WB;
            default:      state_q <= ST_FETCH;
          endcase
          ST_MEM:  if (ack_v) state_q <= (cls == CL_LD) ? ST_WB : ST_FETCH;
          default: state_q <= ST_FETCH;
        endcase
`ifdef MC_CTRL_TRAP_EN
        // Counter is zero everywhere except while a request is outstanding
        if (mem_req && !mem_ack) begin
          if (tmo_q == TMO_LAST) begin
            tmo_q   <= '0;
            state_q <= ST_TRAP;
          end else begin
            tmo_q <= tmo_q + TMO_W'(1);
          end
        end else begin
          tmo_q <= '0;
        end
`endif
      end
    end
  end

  always_comb begin
    ir_wr  = 1'b0;
    pc_wr  = 1'b0;
    rf_wr  = 1'b0;
    ret    = 1'b0;
    mem_we = 1'b0;
    alu_en = 1'b0;
    NPCOp  = NPC_PLUS4;
    GPRSel = GPRSel_RD;
    WDSel  = WDSel_FromALU;
    case (state_q)
      ST_FETCH: begin
        ir_wr = ack_v;
        pc_wr = ack_v;
      end
      ST_DECODE: case (cls)
        CL_J: begin
          pc_wr = 1'b1; NPCOp = NPC_JUMP; ret = 1'b1;
        end
        CL_JAL: begin
          pc_wr = 1'b1; NPCOp = NPC_JUMP; ret = 1'b1;
          rf_wr = 1'b1; GPRSel = GPRSel_RA; WDSel = WDSel_FromPC;
        end
`ifndef MC_CTRL_TRAP_EN
        CL_ILL: ret = 1'b1;
`endif
        default: ;
      endcase
      ST_EXEC: begin
        alu_en = 1'b1;
        case (cls)
          CL_BR: begin
            NPCOp = NPC_BRANCH;
            pc_wr = (op_q == OP_BNE) ? ~Zero : Zero;
            ret   = 1'b1;
          end
          CL_JR: begin
            pc_wr = 1'b1; NPCOp = NPC_JR; ret = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        alu_en = 1'b1;
        mem_we = (cls == CL_ST);
        ret    = ack_v & (cls == CL_ST);
      end
      ST_WB: begin
        alu_en = 1'b1;
        rf_wr  = 1'b1;
        GPRSel = (cls == CL_R) ? GPRSel_RD : GPRSel_RT;
        WDSel  = (cls == CL_LD) ? WDSel_FromMEM : WDSel_FromALU;
        ret    = 1'b1;
      end
`ifdef MC_CTRL_TRAP_EN
      ST_TRAP: begin
        pc_wr = 1'b1; NPCOp = NPC_EXCEPT;
      end
`endif
      default: ;
    endcase
  end

  assign IRWr   = ir_wr & ~stall;
  assign PCWr   = pc_wr & ~stall;
  assign RFWr   = rf_wr & ~stall;
  assign retire = ret & ~stall;
  assign ALUOp  = alu_en ? dec_alu : '0;
  assign ASel   = alu_en & dec_asel;
  assign BSel   = alu_en & dec_bsel;
  assign EXTOp  = alu_en ? dec_ext : EXT_ZERO;
  assign state  = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-instruction cycle traces, strobes and selects,
// stall and async-reset behaviour; MC_CTRL_TRAP_EN selects the trap checks.
module tb_mc_ctrl;

  logic       clk, rstn;
  logic [5:0] opcode, funct;
  logic       Zero, stall, mem_ack;
  logic       mem_req, mem_we, IRWr, PCWr, RFWr, ASel, BSel, retire;
  logic [4:0] ALUOp;
  logic [2:0] NPCOp, WDSel, state;
  logic [1:0] EXTOp, GPRSel;

  int n_err = 0;
  int n_chk = 0;

  int          r_cyc, r_rf, r_ir, r_retn;
  logic [31:0] r_trace;
  logic [1:0]  r_gpr;
  logic [2:0]  r_wd, r_rfst;
  logic [4:0]  r_alu;
  logic [7:0]  r_npc;
  logic        r_we;
  logic [3:0]  r_exec;

  mc_ctrl dut (
    .clk(clk), .rstn(rstn), .opcode(opcode), .funct(funct), .Zero(Zero),
    .stall(stall), .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we),
    .IRWr(IRWr), .PCWr(PCWr), .RFWr(RFWr), .ALUOp(ALUOp), .NPCOp(NPCOp),
    .EXTOp(EXTOp), .GPRSel(GPRSel), .WDSel(WDSel), .ASel(ASel), .BSel(BSel),
    .retire(retire), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic a, input logic z, input logic s);
    mem_ack = a; Zero = z; stall = s;
    #1;
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  // Runs one instruction from FETCH; fw/mw = wait cycles before ack in FETCH/MEM
  task automatic run(input logic [5:0] op, input logic [5:0] fn, input int fw,
                     input int mw, input logic z, input logic ack_hi);
    int fc, mc;
    logic a;
    bit done;
    fc = 0; mc = 0; done = 0;
    opcode = op; funct = fn;
    r_cyc = 0; r_rf = 0; r_ir = 0; r_retn = 0; r_trace = '0; r_gpr = '0;
    r_wd = '0; r_rfst = '0; r_alu = '0; r_npc = '0; r_we = 1'b0; r_exec = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (ack_hi)              a = 1'b1;
      else if (state == 3'd0)  a = (fc >= fw);
      else if (state == 3'd3)  a = (mc >= mw);
      else                     a = 1'b0;
      if (state == 3'd0 && !a) fc++;
      if (state == 3'd3 && !a) mc++;
      drive(a, z, 1'b0);
      r_cyc++;
      r_trace = {r_trace[28:0], state};
      if (IRWr) r_ir++;
      if (RFWr) begin
        r_rf++; r_gpr = GPRSel; r_wd = WDSel; r_alu = ALUOp; r_rfst = state;
      end
      if (PCWr && state != 3'd0) r_npc[NPCOp] = 1'b1;
      if (mem_we) r_we = 1'b1;
      if (state == 3'd2) r_exec = {ASel, BSel, EXTOp};
      if (retire) begin r_retn++; done = 1; end
      if (state == 3'd5) done = 1;
      step;
    end
    mem_ack = 1'b0;
    chk("run_bound", 32'(done), 32'd1);
  endtask

  initial begin
    rstn = 1'b0; opcode = '0; funct = '0; Zero = 1'b0; stall = 1'b0; mem_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_outs", 32'({mem_we, IRWr, PCWr, RFWr, retire, ASel, BSel, ALUOp,
                         NPCOp, EXTOp, GPRSel, WDSel}), 32'd0);
    step;
    rstn = 1'b1;
    step;
    chk("first_req", 32'(mem_req), 32'd1);

    // addu, ack held high throughout
    run(6'h00, 6'h21, 0, 0, 1'b0, 1'b1);
    chk("addu_trace", r_trace, 'o0124);
    chk("addu_cyc", r_cyc, 4);
    chk("addu_ir", r_ir, 1);
    chk("addu_rf", r_rf, 1);
    chk("addu_rfst", 32'(r_rfst), 32'd4);
    chk("addu_gpr", 32'(r_gpr), 32'd0);
    chk("addu_alu", 32'(r_alu), 32'd2);

    // lw with two wait cycles in FETCH and MEM
    run(6'h23, 6'h00, 2, 2, 1'b0, 1'b0);
    chk("lw_trace", r_trace, 'o123334);
    chk("lw_cyc", r_cyc, 9);
    chk("lw_we", 32'(r_we), 32'd0);
    chk("lw_wd", 32'(r_wd), 32'd1);
    chk("lw_gpr", 32'(r_gpr), 32'd1);
    chk("lw_alu", 32'(r_alu), 32'd1);

    run(6'h04, 6'h00, 0, 0, 1'b1, 1'b0);
    chk("beq_trace", r_trace, 'o012);
    chk("beq_npc", 32'(r_npc), 32'h02);
    chk("beq_ret", r_retn, 1);
    run(6'h05, 6'h00, 0, 0, 1'b1, 1'b0);
    chk("bne_z1_npc", 32'(r_npc), 32'h00);
    chk("bne_z1_cyc", r_cyc, 3);
    run(6'h05, 6'h00, 0, 0, 1'b0, 1'b0);
    chk("bne_z0_npc", 32'(r_npc), 32'h02);

    run(6'h03, 6'h00, 0, 0, 1'b0, 1'b0);
    chk("jal_cyc", r_cyc, 2);
    chk("jal_rf", r_rf, 1);
    chk("jal_gpr", 32'(r_gpr), 32'd2);
    chk("jal_wd", 32'(r_wd), 32'd2);
    chk("jal_npc", 32'(r_npc), 32'h04);

    run(6'h02, 6'h00, 0, 0, 1'b0, 1'b0);
    chk("j_cyc", r_cyc, 2);
    chk("j_rf", r_rf, 0);
    run(6'h00, 6'h08, 0, 0, 1'b0, 1'b0);
    chk("jr_cyc", r_cyc, 3);
    chk("jr_npc", 32'(r_npc), 32'h08);

    run(6'h2B, 6'h00, 0, 0, 1'b0, 1'b0);
    chk("sw_trace", r_trace, 'o0123);
    chk("sw_we", 32'(r_we), 32'd1);
    chk("sw_ret", r_retn, 1);

    run(6'h00, 6'h00, 0, 0, 1'b0, 1'b0);
    chk("sll_exec", 32'(r_exec), 32'b1000);
    chk("sll_alu", 32'(r_alu), 32'd10);
    run(6'h08, 6'h00, 1, 0, 1'b0, 1'b0);
    chk("addi_cyc", r_cyc, 5);
    chk("addi_exec", 32'(r_exec), 32'b0101);
    chk("addi_gpr", 32'(r_gpr), 32'd1);
    run(6'h0D, 6'h00, 0, 0, 1'b0, 1'b0);
    chk("ori_exec", 32'(r_exec), 32'b0100);
    chk("ori_alu", 32'(r_alu), 32'd6);

`ifdef MC_CTRL_TRAP_EN
    run(6'h3F, 6'h00, 0, 0, 1'b0, 1'b0);
    chk("ill_trace", r_trace, 'o015);
    chk("ill_npc", 32'(r_npc), 32'h10);
    chk("ill_ret", r_retn, 0);
    run(6'h2B, 6'h00, 0, 99, 1'b0, 1'b0);
    chk("tmo_cyc", r_cyc, 19);
    chk("tmo_tail", r_trace & 'o77, 'o35);
    chk("tmo_npc", 32'(r_npc), 32'h10);
    chk("tmo_ret", r_retn, 0);
`else
    run(6'h3F, 6'h00, 0, 0, 1'b0, 1'b0);
    chk("ill_trace", r_trace, 'o01);
    chk("ill_ret", r_retn, 1);
    chk("ill_npc", 32'(r_npc), 32'h00);
`endif

    // stall: ack ignored in FETCH, then 3 frozen cycles in WB
    opcode = 6'h00; funct = 6'h21;
    drive(1'b1, 1'b0, 1'b1);
    chk("stf_ir", 32'(IRWr), 32'd0);
    chk("stf_req", 32'(mem_req), 32'd1);
    step;
    drive(1'b1, 1'b0, 1'b0);
    chk("stf_state", 32'(state), 32'd0);
    step;
    drive(1'b0, 1'b0, 1'b0);
    step;
    step;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1);
      chk("stwb_state", 32'(state), 32'd4);
      chk("stwb_rf", 32'({RFWr, retire}), 32'd0);
      step;
    end
    drive(1'b0, 1'b0, 1'b0);
    chk("stwb_rel", 32'({RFWr, retire}), 32'b11);
    step;

    // async reset in the middle of a store
    opcode = 6'h2B; funct = 6'h00;
    drive(1'b1, 1'b0, 1'b0);
    step;
    drive(1'b0, 1'b0, 1'b0);
    step;
    step;
    chk("mem_pre", 32'({state, mem_req, mem_we}), 32'({3'd3, 2'b11}));
    #2 rstn = 1'b0;
    #1;
    chk("mem_rst", 32'({state, mem_req, mem_we}), 32'd0);
    step;
    rstn = 1'b1;
    step;
    run(6'h00, 6'h21, 0, 0, 1'b0, 1'b0);
    chk("post_rst_cyc", r_cyc, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
